// File: rtl/crf_multi_channel.sv
// crf_multi_channel: AXI4-Lite configuration register file for the upsampling
// accelerator. Holds run control (start/abort), completion status with a
// maskable level interrupt, per-channel sticky done bits and one saturating
// handshake counter per parallel channel. A three-state run controller
// (IDLE/RUN/DONE) drives the access_control strobes.
//
// Handshake semantics (all AXI channels): a transfer happens on a rising clk
// edge where valid and ready are both 1. A source holds valid and its payload
// stable until that edge; ready may depend on internal state only, never on
// the matching valid.
module crf_multi_channel #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int CRF_DATA_WIDTH = 32,
  parameter int N_PARALLEL     = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_axi_awvalid,
  output logic                        s_axi_awready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                        s_axi_wvalid,
  output logic                        s_axi_wready,
  input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  output logic                        s_axi_bvalid,
  input  logic                        s_axi_bready,
  output logic [1:0]                  s_axi_bresp,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  output logic                        s_axi_rvalid,
  input  logic                        s_axi_rready,
  output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                  s_axi_rresp,
  input  logic [N_PARALLEL-1:0]       ch_tvalid,
  input  logic [N_PARALLEL-1:0]       ch_tready,
  input  logic [N_PARALLEL-1:0]       ch_done,
  output logic                        crf_ac_UPSTART,
  output logic                        crf_ac_UPEND,
  output logic                        crf_ac_busy,
  output logic                        interrupt_updone,
  output logic [1:0]                  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } run_state_t;

  localparam int IDX_W = 6;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [CRF_DATA_WIDTH-1:0] CNT_ONE = CRF_DATA_WIDTH'(1);
  localparam logic [CRF_DATA_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(4 + N_PARALLEL);

  // Word index 0..3 are control registers, 4..4+N-1 the channel counters.
  localparam logic [IDX_W-1:0] IDX_UPSTR  = 6'd0;
  localparam logic [IDX_W-1:0] IDX_UPENDR = 6'd1;
  localparam logic [IDX_W-1:0] IDX_UPIMR  = 6'd2;

  // ready_en keeps every ready low while in reset and for the first edge after.
  logic                      ready_en;
  logic                      aw_full;
  logic                      w_full;
  logic [IDX_W-1:0]          aw_idx_q;
  logic [1:0]                w_bits_q;
  logic                      w_strb0_q;
  logic                      aw_hs;
  logic                      w_hs;
  logic                      ar_hs;
  logic                      wr_commit;
  logic                      wr_mapped;
  logic                      wr_act;
  logic                      start_cmd;
  logic                      abort_cmd;
  logic                      w1c_cmd;
  logic                      imr_we;

  logic [IDX_W-1:0]          rd_idx;
  logic                      rd_mapped;
  logic [AXI_DATA_WIDTH-1:0] rd_val;

  run_state_t                state_q;
  run_state_t                state_d;
  logic                      go_run;
  logic                      set_done;
  logic                      done_status;
  logic                      imr;
  logic [N_PARALLEL-1:0]     done_mask;
  logic [N_PARALLEL-1:0]     mask_upd;
  logic [CRF_DATA_WIDTH-1:0] cnt [N_PARALLEL];

  // Address/data bits outside the decoded window carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awaddr[AXI_ADDR_WIDTH-1:8], s_axi_awaddr[1:0],
                           s_axi_araddr[AXI_ADDR_WIDTH-1:8], s_axi_araddr[1:0],
                           s_axi_wdata[AXI_DATA_WIDTH-1:2],
                           s_axi_wstrb[AXI_DATA_WIDTH/8-1:1]};

  assign s_axi_awready = ready_en & ~aw_full & ~s_axi_bvalid;
  assign s_axi_wready  = ready_en & ~w_full & ~s_axi_bvalid;
  assign s_axi_arready = ready_en & ~s_axi_rvalid;

  assign aw_hs     = s_axi_awvalid & s_axi_awready;
  assign w_hs      = s_axi_wvalid & s_axi_wready;
  assign ar_hs     = s_axi_arvalid & s_axi_arready;
  assign wr_commit = aw_full & w_full & ~s_axi_bvalid;
  assign wr_mapped = (aw_idx_q < IDX_END);
  assign wr_act    = wr_commit & w_strb0_q;
  assign start_cmd = wr_act & (aw_idx_q == IDX_UPSTR) & w_bits_q[0];
  assign abort_cmd = wr_act & (aw_idx_q == IDX_UPSTR) & w_bits_q[1];
  assign w1c_cmd   = wr_act & (aw_idx_q == IDX_UPENDR) & w_bits_q[0];
  assign imr_we    = wr_act & (aw_idx_q == IDX_UPIMR);

  // Write address/data holding slots and the write response channel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_en     <= 1'b0;
      aw_full      <= 1'b0;
      w_full       <= 1'b0;
      aw_idx_q     <= '0;
      w_bits_q     <= '0;
      w_strb0_q    <= 1'b0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
    end else begin
      ready_en <= 1'b1;
      if (aw_hs) begin
        aw_full  <= 1'b1;
        aw_idx_q <= s_axi_awaddr[7:2];
      end else if (wr_commit) begin
        aw_full <= 1'b0;
      end
      if (w_hs) begin
        w_full    <= 1'b1;
        w_bits_q  <= s_axi_wdata[1:0];
        w_strb0_q <= s_axi_wstrb[0];
      end else if (wr_commit) begin
        w_full <= 1'b0;
      end
      if (wr_commit) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

  assign rd_idx = s_axi_araddr[7:2];

  // Read mux over the current (pre-commit) register values.
  always_comb begin
    rd_val    = '0;
    rd_mapped = (rd_idx < IDX_END);
    case (rd_idx)
      6'd0: rd_val[1:0] = {crf_ac_busy, crf_ac_UPEND};
      6'd1: rd_val[0] = done_status;
      6'd2: rd_val[0] = imr;
      6'd3: rd_val[N_PARALLEL-1:0] = done_mask;
      default: begin
        for (int i = 0; i < N_PARALLEL; i++) begin
          if (rd_idx == IDX_W'(4 + i)) rd_val[CRF_DATA_WIDTH-1:0] = cnt[i];
        end
      end
    endcase
  end

  // Read data channel: capture at AR acceptance, hold until rready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= rd_mapped ? rd_val : '0;
      s_axi_rresp  <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
    end else if (s_axi_rvalid && s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

  assign mask_upd = done_mask | ch_done;

  // Run-control state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode; abort beats start, start is ignored while running.
  always_comb begin
    state_d  = state_q;
    go_run   = 1'b0;
    set_done = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_cmd && !abort_cmd) begin
          state_d = ST_RUN;
          go_run  = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort_cmd) begin
          state_d = ST_IDLE;
        end else if (&mask_upd) begin
          state_d  = ST_DONE;
          set_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign crf_ac_busy  = (state_q == ST_RUN);
  assign crf_ac_UPEND = (state_q == ST_DONE);
  assign dbg_state    = state_q;

  // Status, mask, sticky done bits, start strobe and registered interrupt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crf_ac_UPSTART   <= 1'b0;
      done_status      <= 1'b0;
      imr              <= 1'b0;
      done_mask        <= '0;
      interrupt_updone <= 1'b0;
    end else begin
      crf_ac_UPSTART <= go_run;
      if (go_run)        done_status <= 1'b0;
      else if (set_done) done_status <= 1'b1;
      else if (w1c_cmd)  done_status <= 1'b0;
      if (imr_we) imr <= w_bits_q[0];
      if (go_run)                  done_mask <= '0;
      else if (state_q == ST_RUN)  done_mask <= mask_upd;
      interrupt_updone <= done_status & ~imr;
    end
  end

  // Per-channel handshake counters: count only in RUN, saturate at all ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_PARALLEL; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_PARALLEL; i++) begin
        if (go_run) begin
          cnt[i] <= '0;
        end else if (state_q == ST_RUN && ch_tvalid[i] && ch_tready[i] &&
                     cnt[i] != CNT_MAX) begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_crf_multi_channel.sv
// Bench for crf_multi_channel: a 32-bit-counter instance plus a 4-bit-counter
// instance sharing every input, checked against a behavioural model.
module tb_crf_multi_channel;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        s_axi_awvalid, s_axi_wvalid, s_axi_bready, s_axi_arvalid, s_axi_rready;
  logic [31:0] s_axi_awaddr, s_axi_araddr, s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic [N-1:0] ch_tvalid, ch_tready, ch_done;

  logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
  logic [1:0]  s_axi_bresp, s_axi_rresp, dbg_state;
  logic [31:0] s_axi_rdata;
  logic        crf_ac_UPSTART, crf_ac_UPEND, crf_ac_busy, interrupt_updone;

  logic        awready_4, wready_4, bvalid_4, arready_4, rvalid_4;
  logic [1:0]  bresp_4, rresp_4, dbg_state_4;
  logic [31:0] rdata_4;
  logic        upstart_4, upend_4, busy_4, irq_4;

  int checks = 0;
  int failures = 0;
  int model_cnt [N];
  logic [31:0] exp_q [$];
  logic [31:0] rd_data, rd_data4;
  logic [1:0]  rd_resp, wr_resp;
  logic        snap_upstart, snap_irq, snap_busy;

  crf_multi_channel #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .CRF_DATA_WIDTH(32), .N_PARALLEL(N)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .ch_tvalid(ch_tvalid), .ch_tready(ch_tready), .ch_done(ch_done),
    .crf_ac_UPSTART(crf_ac_UPSTART), .crf_ac_UPEND(crf_ac_UPEND), .crf_ac_busy(crf_ac_busy),
    .interrupt_updone(interrupt_updone), .dbg_state(dbg_state)
  );

  crf_multi_channel #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .CRF_DATA_WIDTH(4), .N_PARALLEL(N)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(awready_4), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(wready_4), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_bvalid(bvalid_4), .s_axi_bready(s_axi_bready), .s_axi_bresp(bresp_4),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(arready_4), .s_axi_araddr(s_axi_araddr),
    .s_axi_rvalid(rvalid_4), .s_axi_rready(s_axi_rready), .s_axi_rdata(rdata_4), .s_axi_rresp(rresp_4),
    .ch_tvalid(ch_tvalid), .ch_tready(ch_tready), .ch_done(ch_done),
    .crf_ac_UPSTART(upstart_4), .crf_ac_UPEND(upend_4), .crf_ac_busy(busy_4),
    .interrupt_updone(irq_4), .dbg_state(dbg_state_4)
  );

  // Advance to 1 time unit after the next active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: issue AW and W together, then take the response.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done, w_done, aw_hit, w_hit;
    int n;
    aw_done = 0; w_done = 0; n = 0; resp = 2'bxx;
    s_axi_awaddr = addr; s_axi_awvalid = 1'b1;
    s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
    s_axi_bready = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      aw_hit = s_axi_awvalid && s_axi_awready;
      w_hit  = s_axi_wvalid && s_axi_wready;
      step();
      if (aw_hit) begin aw_done = 1; s_axi_awvalid = 1'b0; end
      if (w_hit)  begin w_done = 1;  s_axi_wvalid = 1'b0;  end
      n++;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin step(); n++; end
    checks++;
    if (!s_axi_bvalid) begin
      failures++;
      $display("FAIL axi_write_timeout addr=%h got bvalid=%b exp=1", addr, s_axi_bvalid);
    end
    resp = s_axi_bresp;
    snap_upstart = crf_ac_UPSTART;
    snap_irq = interrupt_updone;
    snap_busy = crf_ac_busy;
    step();
    s_axi_bready = 1'b0;
  endtask

  // Driver: issue AR, then capture read data from both instances.
  task automatic axi_read(input logic [31:0] addr);
    int n;
    bit hit;
    n = 0; hit = 0;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    while (!hit && n < 20) begin
      hit = s_axi_arvalid && s_axi_arready;
      step();
      n++;
    end
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin step(); n++; end
    checks++;
    if (!s_axi_rvalid) begin
      failures++;
      $display("FAIL axi_read_timeout addr=%h got rvalid=%b exp=1", addr, s_axi_rvalid);
    end
    rd_data = s_axi_rdata; rd_data4 = rdata_4; rd_resp = s_axi_rresp;
    s_axi_rready = 1'b1;
    step();
    s_axi_rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [44:0] outs;
    logic [31:0] addrs [8];
    addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C};
    rst_n = 1'b0;
    repeat (3) step();
    outs = {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready, s_axi_rvalid,
            s_axi_rresp, s_axi_rdata, crf_ac_UPSTART, crf_ac_UPEND, crf_ac_busy, interrupt_updone};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", outs); end
    rst_n = 1'b1;
    step();
    checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
      failures++;
      $display("FAIL ready_after_reset got=%b exp=111", {s_axi_awready, s_axi_wready, s_axi_arready});
    end
    foreach (addrs[i]) begin
      axi_read(addrs[i]);
      checks++;
      if (rd_data !== 32'h0 || rd_resp !== 2'b00) begin
        failures++;
        $display("FAIL reset_read addr=%h got data=%h resp=%b exp data=0 resp=00", addrs[i], rd_data, rd_resp);
      end
    end
  endtask

  task automatic test_start_count();
    logic [3:0] v, r;
    logic [31:0] e;
    axi_write(32'h00, 32'h1, 4'hF, wr_resp);
    checks++;
    if (snap_upstart !== 1'b1 || snap_busy !== 1'b1 || wr_resp !== 2'b00) begin
      failures++;
      $display("FAIL start_strobe got upstart=%b busy=%b resp=%b exp 1 1 00", snap_upstart, snap_busy, wr_resp);
    end
    checks++;
    if (crf_ac_UPSTART !== 1'b0) begin failures++; $display("FAIL upstart_width got=%b exp=0", crf_ac_UPSTART); end
    foreach (model_cnt[i]) model_cnt[i] = 0;
    for (int i = 0; i < 8; i++) begin
      ch_tvalid = {2'b00, 1'b1, (i < 5)};
      ch_tready = {2'b00, (i % 3 == 0), 1'b1};
      step();
    end
    ch_tvalid = '0; ch_tready = '0;
    model_cnt[0] = 5; model_cnt[1] = 3;
    axi_read(32'h10);
    checks++;
    if (rd_data !== 32'd5) begin failures++; $display("FAIL hskcnt0 got=%0d exp=5", rd_data); end
    axi_read(32'h14);
    checks++;
    if (rd_data !== 32'd3) begin failures++; $display("FAIL hskcnt1 got=%0d exp=3", rd_data); end
    axi_read(32'h00);
    checks++;
    if (rd_data !== 32'h2) begin failures++; $display("FAIL upstr_busy got=%h exp=2", rd_data); end
    for (int c = 0; c < 60; c++) begin
      v = 4'($urandom_range(0, 15));
      r = 4'($urandom_range(0, 15));
      ch_tvalid = v; ch_tready = r;
      for (int i = 0; i < N; i++) if (v[i] && r[i]) model_cnt[i]++;
      step();
    end
    ch_tvalid = '0; ch_tready = '0;
    for (int i = 0; i < N; i++) exp_q.push_back(32'(model_cnt[i]));
    for (int i = 0; i < N; i++) begin
      axi_read(32'h10 + 32'(4 * i));
      e = exp_q.pop_front();
      checks++;
      if (rd_data !== e) begin failures++; $display("FAIL hskcnt_rand ch=%0d got=%0d exp=%0d", i, rd_data, e); end
      checks++;
      if (rd_data4 !== ((e > 15) ? 32'd15 : e)) begin
        failures++;
        $display("FAIL hskcnt4_rand ch=%0d got=%0d exp=%0d", i, rd_data4, (e > 15) ? 32'd15 : e);
      end
    end
  endtask

  task automatic test_done_irq();
    for (int k = 0; k < N; k++) begin
      if (k == N - 1) begin
        checks++;
        if (crf_ac_UPEND !== 1'b0 || crf_ac_busy !== 1'b1) begin
          failures++;
          $display("FAIL done_early got upend=%b busy=%b exp 0 1", crf_ac_UPEND, crf_ac_busy);
        end
      end
      ch_done = '0;
      ch_done[k] = 1'b1;
      step();
    end
    ch_done = '0;
    checks++;
    if (crf_ac_UPEND !== 1'b1 || crf_ac_busy !== 1'b0 || interrupt_updone !== 1'b0) begin
      failures++;
      $display("FAIL done_entry got upend=%b busy=%b irq=%b exp 1 0 0", crf_ac_UPEND, crf_ac_busy, interrupt_updone);
    end
    step();
    checks++;
    if (interrupt_updone !== 1'b1) begin failures++; $display("FAIL irq_rise got=%b exp=1", interrupt_updone); end
    axi_read(32'h0C);
    checks++;
    if (rd_data !== 32'hF) begin failures++; $display("FAIL donemask got=%h exp=f", rd_data); end
    axi_read(32'h04);
    checks++;
    if (rd_data !== 32'h1) begin failures++; $display("FAIL upendr_set got=%h exp=1", rd_data); end
    axi_write(32'h04, 32'h1, 4'h1, wr_resp);
    checks++;
    if (interrupt_updone !== 1'b0 || crf_ac_UPEND !== 1'b1) begin
      failures++;
      $display("FAIL w1c got irq=%b upend=%b exp 0 1", interrupt_updone, crf_ac_UPEND);
    end
    axi_read(32'h00);
    checks++;
    if (rd_data !== 32'h1) begin failures++; $display("FAIL upstr_done got=%h exp=1", rd_data); end
  endtask

  task automatic test_mask();
    axi_write(32'h08, 32'h1, 4'hF, wr_resp);
    axi_read(32'h08);
    checks++;
    if (rd_data !== 32'h1) begin failures++; $display("FAIL imr_rw got=%h exp=1", rd_data); end
    axi_write(32'h00, 32'h1, 4'hF, wr_resp);
    axi_read(32'h10);
    checks++;
    if (rd_data !== 32'h0) begin failures++; $display("FAIL cnt_cleared got=%h exp=0", rd_data); end
    axi_read(32'h0C);
    checks++;
    if (rd_data !== 32'h0) begin failures++; $display("FAIL mask_cleared got=%h exp=0", rd_data); end
    ch_done = '1;
    step();
    ch_done = '0;
    checks++;
    if (crf_ac_UPEND !== 1'b1) begin failures++; $display("FAIL masked_done got=%b exp=1", crf_ac_UPEND); end
    repeat (3) step();
    checks++;
    if (interrupt_updone !== 1'b0) begin failures++; $display("FAIL irq_masked got=%b exp=0", interrupt_updone); end
    axi_read(32'h04);
    checks++;
    if (rd_data !== 32'h1) begin failures++; $display("FAIL masked_status got=%h exp=1", rd_data); end
    axi_write(32'h08, 32'h0, 4'hF, wr_resp);
    checks++;
    if (snap_irq !== 1'b0 || interrupt_updone !== 1'b1) begin
      failures++;
      $display("FAIL unmask_lag got before=%b after=%b exp 0 1", snap_irq, interrupt_updone);
    end
    axi_write(32'h04, 32'h1, 4'hF, wr_resp);
  endtask

  task automatic test_write_timing();
    s_axi_bready = 1'b0;
    s_axi_awaddr = 32'h08; s_axi_awvalid = 1'b1;
    step();
    s_axi_awvalid = 1'b0;
    checks++;
    if (s_axi_awready !== 1'b0 || s_axi_wready !== 1'b1) begin
      failures++;
      $display("FAIL aw_slot got awready=%b wready=%b exp 0 1", s_axi_awready, s_axi_wready);
    end
    repeat (2) step();
    checks++;
    if (s_axi_bvalid !== 1'b0) begin failures++; $display("FAIL bvalid_early got=%b exp=0", s_axi_bvalid); end
    s_axi_wdata = 32'h0; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    step();
    s_axi_wvalid = 1'b0;
    checks++;
    if (s_axi_bvalid !== 1'b0) begin failures++; $display("FAIL bvalid_w_edge got=%b exp=0", s_axi_bvalid); end
    step();
    checks++;
    if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00) begin
      failures++;
      $display("FAIL commit_edge got bvalid=%b bresp=%b exp 1 00", s_axi_bvalid, s_axi_bresp);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (s_axi_bvalid !== 1'b1 || s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0) begin
        failures++;
        $display("FAIL bresp_hold cyc=%0d got bvalid=%b awready=%b wready=%b exp 1 0 0",
                 i, s_axi_bvalid, s_axi_awready, s_axi_wready);
      end
    end
    s_axi_bready = 1'b1;
    step();
    s_axi_bready = 1'b0;
    checks++;
    if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1) begin
      failures++;
      $display("FAIL bresp_release got bvalid=%b awready=%b exp 0 1", s_axi_bvalid, s_axi_awready);
    end
    axi_write(32'h80, 32'h3, 4'hF, wr_resp);
    checks++;
    if (wr_resp !== 2'b10) begin failures++; $display("FAIL unmapped_wr_0x80 got=%b exp=10", wr_resp); end
    axi_write(32'h20, 32'h1, 4'hF, wr_resp);
    checks++;
    if (wr_resp !== 2'b10) begin failures++; $display("FAIL unmapped_wr_0x20 got=%b exp=10", wr_resp); end
    axi_write(32'h0C, 32'h1, 4'hF, wr_resp);
    checks++;
    if (wr_resp !== 2'b00) begin failures++; $display("FAIL ro_write_resp got=%b exp=00", wr_resp); end
    axi_write(32'h08, 32'h1, 4'h0, wr_resp);
    axi_read(32'h08);
    checks++;
    if (rd_data !== 32'h0) begin failures++; $display("FAIL wstrb0_ignored got=%h exp=0", rd_data); end
    axi_read(32'h80);
    checks++;
    if (rd_data !== 32'h0 || rd_resp !== 2'b10) begin
      failures++;
      $display("FAIL unmapped_rd got data=%h resp=%b exp 0 10", rd_data, rd_resp);
    end
    checks++;
    if (crf_ac_UPEND !== 1'b1) begin failures++; $display("FAIL state_kept got upend=%b exp=1", crf_ac_UPEND); end
  endtask

  task automatic test_abort();
    axi_write(32'h00, 32'h1, 4'hF, wr_resp);
    ch_tvalid = 4'b0001; ch_tready = 4'b0001;
    repeat (20) step();
    ch_tvalid = '0; ch_tready = '0;
    model_cnt[0] = 20;
    ch_done = 4'b0011;
    step();
    ch_done = '0;
    axi_read(32'h10);
    checks++;
    if (rd_data !== 32'd20) begin failures++; $display("FAIL cnt20 got=%0d exp=20", rd_data); end
    checks++;
    if (rd_data4 !== 32'd15) begin failures++; $display("FAIL cnt_saturate got=%0d exp=15", rd_data4); end
    axi_write(32'h00, 32'h3, 4'hF, wr_resp);
    checks++;
    if (snap_busy !== 1'b0 || crf_ac_busy !== 1'b0 || crf_ac_UPEND !== 1'b0) begin
      failures++;
      $display("FAIL abort got busy=%b upend=%b exp 0 0", crf_ac_busy, crf_ac_UPEND);
    end
    repeat (2) step();
    checks++;
    if (interrupt_updone !== 1'b0) begin failures++; $display("FAIL abort_irq got=%b exp=0", interrupt_updone); end
    axi_read(32'h04);
    checks++;
    if (rd_data !== 32'h0) begin failures++; $display("FAIL abort_status got=%h exp=0", rd_data); end
    ch_tvalid = 4'hF; ch_tready = 4'hF;
    repeat (10) step();
    ch_tvalid = '0; ch_tready = '0;
    axi_read(32'h10);
    checks++;
    if (rd_data !== 32'(model_cnt[0])) begin failures++; $display("FAIL cnt_frozen got=%0d exp=%0d", rd_data, model_cnt[0]); end
    axi_write(32'h00, 32'h3, 4'hF, wr_resp);
    checks++;
    if (snap_upstart !== 1'b0 || crf_ac_busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_wins got upstart=%b busy=%b exp 0 0", snap_upstart, crf_ac_busy);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [44:0] outs;
    axi_write(32'h00, 32'h1, 4'hF, wr_resp);
    ch_tvalid = 4'b0010; ch_tready = 4'b0010;
    repeat (4) step();
    ch_tvalid = '0; ch_tready = '0;
    s_axi_awaddr = 32'h08; s_axi_awvalid = 1'b1;
    step();
    s_axi_awvalid = 1'b0;
    s_axi_araddr = 32'h14; s_axi_arvalid = 1'b1;
    step();
    s_axi_arvalid = 1'b0;
    rst_n = 1'b0;
    step();
    outs = {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready, s_axi_rvalid,
            s_axi_rresp, s_axi_rdata, crf_ac_UPSTART, crf_ac_UPEND, crf_ac_busy, interrupt_updone};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL midrun_reset got=%h exp=0", outs); end
    rst_n = 1'b1;
    step();
    checks++;
    if (s_axi_awready !== 1'b1 || s_axi_bvalid !== 1'b0) begin
      failures++;
      $display("FAIL slot_dropped got awready=%b bvalid=%b exp 1 0", s_axi_awready, s_axi_bvalid);
    end
    axi_read(32'h14);
    checks++;
    if (rd_data !== 32'h0) begin failures++; $display("FAIL cnt_after_reset got=%h exp=0", rd_data); end
    axi_write(32'h08, 32'h1, 4'hF, wr_resp);
    axi_read(32'h08);
    checks++;
    if (rd_data !== 32'h1) begin failures++; $display("FAIL write_after_reset got=%h exp=1", rd_data); end
  endtask

  initial begin
    rst_n = 1'b0;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    s_axi_awaddr = '0; s_axi_araddr = '0; s_axi_wdata = '0; s_axi_wstrb = '0;
    ch_tvalid = '0; ch_tready = '0; ch_done = '0;
    test_reset();
    test_start_count();
    test_done_irq();
    test_mask();
    test_write_timing();
    test_abort();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end
endmodule
